// File: rtl/pps_source_ctrl_if.sv
// Software second-load handshake between the register block (master) and
// pps_source_ctrl (slave).
interface pps_source_ctrl_if;
  logic        set_sec_req_i;
  logic [31:0] set_sec_val_i;
  logic        load_sec_o;
  logic [31:0] update_sec_o;
  logic        set_sec_busy_o;

  modport master (
    output set_sec_req_i, set_sec_val_i,
    input  load_sec_o, update_sec_o, set_sec_busy_o
  );

  modport slave (
    input  set_sec_req_i, set_sec_val_i,
    output load_sec_o, update_sec_o, set_sec_busy_o
  );
endinterface

// File: rtl/pps_source_ctrl.sv
// External PPS qualifier and source selector: measures external PPS intervals,
// locks after N good intervals, falls back to internal PPS, and aligns second loads.
module pps_source_ctrl #(
  parameter int CNT_W  = 32,
  parameter int GOOD_W = 4,
  parameter int MISS_W = 16
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_n_i,
  input  logic                en_i,
  input  logic                ext_pps_flag_i,
  input  logic                int_pps_flag_i,
  input  logic [CNT_W-1:0]    nominal_i,
  input  logic [15:0]         tol_i,
  input  logic [GOOD_W-1:0]   good_count_i,
  input  logic                miss_clr_i,
  pps_source_ctrl_if.slave    sec,
  output logic                pps_flag_o,
  output logic                use_ext_o,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    period_o,
  output logic [MISS_W-1:0]   miss_count_o
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                miss_inc;
  logic [CNT_W-1:0]    cnt_q, period_q;
  logic                pps_q;
  logic                pend_q;
  logic [31:0]         sec_val_q;

  // Acceptance window, computed one bit wider so overflow/borrow is visible.
  logic [CNT_W:0]      hi_w, lo_w;
  logic [CNT_W-1:0]    win_hi, win_lo;
  logic                in_win, good_flag, bad_flag, timeout;

  assign hi_w   = {1'b0, nominal_i} + (CNT_W+1)'(tol_i);
  assign lo_w   = {1'b0, nominal_i} - (CNT_W+1)'(tol_i);
  assign win_hi = hi_w[CNT_W] ? '1 : hi_w[CNT_W-1:0];
  assign win_lo = lo_w[CNT_W] ? '0 : lo_w[CNT_W-1:0];

  assign in_win    = (cnt_q >= win_lo) && (cnt_q <= win_hi);
  assign good_flag = ext_pps_flag_i && in_win;
  assign bad_flag  = ext_pps_flag_i && !in_win;
  assign timeout   = !ext_pps_flag_i && (cnt_q > win_hi);

  // Lock threshold: a programmed zero still needs one good interval.
  logic [GOOD_W-1:0]   good_req;
  logic [GOOD_W:0]     good_inc;
  logic                good_reach;

  assign good_req   = (good_count_i == '0) ? GOOD_W'(1) : good_count_i;
  assign good_inc   = {1'b0, good_q} + (GOOD_W+1)'(1);
  assign good_reach = good_inc >= {1'b0, good_req};

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_HOLD;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    miss_inc = 1'b0;
    if (!en_i) begin
      state_d = ST_HOLD;
      good_d  = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          // First flag only establishes the reference edge.
          if (ext_pps_flag_i) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ: begin
          if (good_flag) begin
            good_d = good_inc[GOOD_W-1:0];
            if (good_reach) state_d = ST_LOCK;
          end else if (bad_flag) begin
            good_d = '0;
          end else if (timeout) begin
            state_d = ST_HOLD;
          end
        end
        ST_LOCK: begin
          if (bad_flag || timeout) begin
            state_d  = ST_HOLD;
            miss_inc = 1'b1;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    miss_d = miss_q;
    if (miss_clr_i)                 miss_d = '0;
    else if (miss_inc && miss_q != '1) miss_d = miss_q + MISS_W'(1);
  end

  // Interval counter, measured period and the one-cycle-late PPS mux.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      cnt_q    <= '0;
      period_q <= '0;
      pps_q    <= 1'b0;
    end else begin
      if (ext_pps_flag_i) begin
        cnt_q    <= CNT_W'(1);
        period_q <= cnt_q;
      end else if (cnt_q != '1) begin
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      pps_q <= (state_q == ST_LOCK) ? good_flag : int_pps_flag_i;
    end
  end

  // Second load: latched request is released on the next selected PPS; a new
  // request in the release cycle re-arms for the following PPS.
  logic load_now;
  assign load_now = pps_q && pend_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      pend_q    <= 1'b0;
      sec_val_q <= '0;
    end else begin
      if (sec.set_sec_req_i) begin
        pend_q    <= 1'b1;
        sec_val_q <= sec.set_sec_val_i;
      end else if (load_now) begin
        pend_q    <= 1'b0;
      end
    end
  end

  assign sec.load_sec_o     = load_now;
  assign sec.update_sec_o   = sec_val_q;
  assign sec.set_sec_busy_o = pend_q;

  assign pps_flag_o   = pps_q;
  assign use_ext_o    = (state_q == ST_LOCK);
  assign state_o      = state_q;
  assign period_o     = period_q;
  assign miss_count_o = miss_q;

endmodule

// File: tb/tb_pps_source_ctrl.sv
// Randomized + directed bench for pps_source_ctrl against a timestamp-based model.
module tb_pps_source_ctrl;
  localparam int CNT_W  = 32;
  localparam int GOOD_W = 4;
  // Narrow miss counter so all-ones saturation is reachable in a short run.
  localparam int MISS_W = 8;
  localparam longint CMAX     = (64'd1 << CNT_W) - 1;
  localparam int     MISS_MAX = (1 << MISS_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en, ext_pps, int_pps, miss_clr;
  logic [CNT_W-1:0]  nominal;
  logic [15:0]       tol;
  logic [GOOD_W-1:0] good_count;
  logic              pps_flag, use_ext;
  logic [1:0]        state;
  logic [CNT_W-1:0]  period;
  logic [MISS_W-1:0] miss_count;

  pps_source_ctrl_if sec_if();

  pps_source_ctrl #(.CNT_W(CNT_W), .GOOD_W(GOOD_W), .MISS_W(MISS_W)) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .en_i           (en),
    .ext_pps_flag_i (ext_pps),
    .int_pps_flag_i (int_pps),
    .nominal_i      (nominal),
    .tol_i          (tol),
    .good_count_i   (good_count),
    .miss_clr_i     (miss_clr),
    .sec            (sec_if),
    .pps_flag_o     (pps_flag),
    .use_ext_o      (use_ext),
    .state_o        (state),
    .period_o       (period),
    .miss_count_o   (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit int_on  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: interval is the cycle distance from the last reference edge.
  longint      cyc = 0, m_ref = 1, m_period = 0;
  int          m_st = 0, m_good = 0, m_miss = 0;
  bit          m_pps = 0, m_pend = 0;
  logic [31:0] m_val = '0;

  task automatic model_reset();
    m_st = 0; m_good = 0; m_miss = 0; m_pps = 0; m_pend = 0; m_val = '0;
    m_period = 0; m_ref = cyc + 1;
  endtask

  task automatic model_step();
    longint meas, hi, lo;
    bit in_win, gflag, bflag, tmo, load, inc, n_pps;
    int need;
    meas = cyc - m_ref;
    if (meas > CMAX) meas = CMAX;
    hi = longint'(nominal) + longint'(tol);
    if (hi > CMAX) hi = CMAX;
    lo = longint'(nominal) - longint'(tol);
    if (lo < 0) lo = 0;
    in_win = (meas >= lo) && (meas <= hi);
    gflag  = ext_pps && in_win;
    bflag  = ext_pps && !in_win;
    tmo    = !ext_pps && (meas > hi);
    load   = m_pps && m_pend;
    n_pps  = (m_st == 2) ? gflag : int_pps;
    need   = (good_count == 0) ? 1 : int'(good_count);
    inc    = 0;
    if (!en) begin
      m_st = 0; m_good = 0;
    end else if (m_st == 0) begin
      if (ext_pps) begin m_st = 1; m_good = 0; end
    end else if (m_st == 1) begin
      if (gflag) begin
        m_good++;
        if (m_good >= need) m_st = 2;
      end else if (bflag) m_good = 0;
      else if (tmo) m_st = 0;
    end else begin
      if (bflag || tmo) begin m_st = 0; inc = 1; end
    end
    if (miss_clr) m_miss = 0;
    else if (inc && m_miss < MISS_MAX) m_miss++;
    if (sec_if.set_sec_req_i) begin m_pend = 1; m_val = sec_if.set_sec_val_i; end
    else if (load) m_pend = 0;
    if (ext_pps) begin m_period = meas; m_ref = cyc; end
    m_pps = n_pps;
  endtask

  task automatic check_all();
    chk("pps", pps_flag, m_pps);
    chk("state", state, m_st);
    chk("use_ext", use_ext, m_st == 2);
    chk("period", period, m_period);
    chk("miss", miss_count, m_miss);
    chk("load", sec_if.load_sec_o, m_pps && m_pend);
    chk("busy", sec_if.set_sec_busy_o, m_pend);
    if (m_pps && m_pend) chk("update", sec_if.update_sec_o, m_val);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pps"}, pps_flag, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_use_ext"}, use_ext, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_miss"}, miss_count, 0);
    chk({tag, "_load"}, sec_if.load_sec_o, 0);
    chk({tag, "_busy"}, sec_if.set_sec_busy_o, 0);
    chk({tag, "_update"}, sec_if.update_sec_o, 0);
  endtask

  function automatic bit rint();
    return int_on && ($urandom_range(0, 7) == 0);
  endfunction

  // One clock: inputs applied at the falling edge, outputs checked at the next one.
  task automatic tick(input bit e, input bit ip, input bit req, input logic [31:0] val);
    ext_pps = e; int_pps = ip;
    sec_if.set_sec_req_i = req; sec_if.set_sec_val_i = val;
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_all();
    ext_pps = 0; int_pps = 0; sec_if.set_sec_req_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, rint(), 0, '0);
  endtask

  task automatic gap(input int n);
    idle(n - 1);
    tick(1, rint(), 0, '0);
  endtask

  task automatic lock_up();
    gap(int'(nominal));
    for (int i = 0; i < ((good_count == 0) ? 1 : int'(good_count)); i++) gap(int'(nominal));
  endtask

  task automatic loss();
    tick(1, 0, 0, '0); tick(0, 0, 0, '0); tick(1, 0, 0, '0); tick(1, 0, 0, '0);
  endtask

  task automatic async_reset(input int hold);
    #2 rst_n = 0;
    #1 check_zero("rst_now");
    repeat (hold) begin
      ext_pps = 1; int_pps = 1;
      @(posedge clk); @(negedge clk);
      check_zero("rst_hold");
    end
    ext_pps = 0; int_pps = 0;
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    int g, miss_before;
    bit found;
    en = 1; ext_pps = 0; int_pps = 0; miss_clr = 0;
    nominal = 1000; tol = 2; good_count = 3;
    sec_if.set_sec_req_i = 0; sec_if.set_sec_val_i = '0;
    #1 check_zero("reset");
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1;

    // Lock at nominal 1000 +/- 2, three good intervals.
    tick(1, 0, 0, '0);
    chk("acq_enter", state, 1);
    gap(1000); gap(1000);
    chk("acq_hold", state, 1);
    gap(1000);
    chk("locked", state, 2);
    chk("lock_flag_not_fwd", pps_flag, 0);
    gap(1000);
    chk("ext_fwd", pps_flag, 1);
    chk("period_1000", period, 1000);

    // Tolerance edges.
    gap(998);  chk("tol_998", state, 2);
    gap(1002); chk("tol_1002", state, 2);
    gap(997);
    chk("tol_997_state", state, 0);
    chk("tol_997_miss", miss_count, 1);
    chk("tol_997_not_fwd", pps_flag, 0);

    // Timeout after relock.
    lock_up();
    chk("relock", state, 2);
    idle(1002); chk("pre_timeout", state, 2);
    idle(1);
    chk("timeout_state", state, 0);
    chk("timeout_miss", miss_count, 2);
    tick(0, 1, 0, '0);
    chk("int_fwd", pps_flag, 1);

    // Second load aligned to the selected PPS.
    tick(0, 0, 1, 32'h1234_5678);
    chk("sl_busy", sec_if.set_sec_busy_o, 1);
    idle(5);
    chk("sl_wait", sec_if.load_sec_o, 0);
    tick(0, 1, 0, '0);
    chk("sl_load", sec_if.load_sec_o, 1);
    chk("sl_value", sec_if.update_sec_o, 32'h1234_5678);
    tick(0, 0, 0, '0);
    chk("sl_clear", sec_if.set_sec_busy_o, 0);
    tick(0, 0, 1, 32'h5555);
    tick(0, 0, 1, 32'hABCD);
    tick(0, 1, 0, '0);
    chk("sl2_value", sec_if.update_sec_o, 32'hABCD);
    // Request in the release cycle re-arms.
    tick(0, 0, 1, 32'h0BAD_F00D);
    chk("rearm_busy", sec_if.set_sec_busy_o, 1);
    int_on = 1; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      idle(1);
      if (sec_if.load_sec_o) found = 1;
    end
    chk("rearm_loaded", found, 1);
    int_on = 0;

    // Enable drop while locked: no miss.
    lock_up();
    chk("en_locked", state, 2);
    miss_before = int'(miss_count);
    en = 0; tick(0, 0, 0, '0);
    chk("en_state", state, 0);
    chk("en_miss", miss_count, miss_before);
    en = 1;

    // Reset mid-ACQUIRE with a load pending.
    tick(1, 0, 0, '0);
    chk("rst_acq", state, 1);
    tick(0, 0, 1, 32'hDEAD_BEEF);
    async_reset(3);
    tick(0, 1, 0, '0);
    chk("rst_no_load", sec_if.load_sec_o, 0);
    chk("rst_pps_int", pps_flag, 1);

    // Miss counter saturation and clear priority.
    nominal = 2; tol = 0; good_count = 1;
    repeat (MISS_MAX) loss();
    chk("miss_full", miss_count, MISS_MAX);
    loss();
    chk("miss_sat", miss_count, MISS_MAX);
    tick(1, 0, 0, '0); tick(0, 0, 0, '0); tick(1, 0, 0, '0);
    miss_clr = 1; tick(1, 0, 0, '0); miss_clr = 0;
    chk("miss_clr_prio", miss_count, 0);

    // Low window clamps at zero.
    nominal = 2; tol = 5; good_count = 1;
    tick(1, 0, 0, '0); tick(1, 0, 0, '0);
    chk("lo_clamp", state, 2);
    en = 0; tick(0, 0, 0, '0); en = 1;

    // High window saturates instead of wrapping.
    nominal = 32'hFFFF_FFFA; tol = 16'd11;
    tick(1, 0, 0, '0);
    idle(40);
    chk("hi_sat", state, 1);

    // Randomized phase.
    int_on = 1; nominal = 10; tol = 2; good_count = 2;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        nominal = $urandom_range(3, 20); tol = $urandom_range(0, 6);
        good_count = $urandom_range(0, 4);
      end
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) g = $urandom_range(1, 40);
      else g = int'(nominal) + int'($urandom_range(0, 6)) - 3;
      if (g < 1) g = 1;
      for (int j = 1; j < g; j++) begin
        miss_clr = ($urandom_range(0, 99) == 0);
        tick(0, rint(), $urandom_range(0, 29) == 0, $urandom);
      end
      miss_clr = ($urandom_range(0, 99) == 0);
      tick(1, rint(), $urandom_range(0, 29) == 0, $urandom);
    end
    miss_clr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
